pimc_irq_rx: RTL

- Per-core receiver for the Platform Interrupt Message Controller (PIMC) notify/lineno/processor_id message.
- Accepts messages addressed to its core and queues the line numbers in a small FIFO.
- Returns the irqack handshake to the PIMC.
- Presents queued lines to the core pipeline through a valid/claim interface, and flags a stuck handshake.

---
 rtl/osmx_irq_pkg.sv | 19 +
 rtl/irq_fifo.sv | 61 ++++++
 rtl/pimc_irq_rx.sv | 111 +++++++++++
 3 files changed

// File: rtl/osmx_irq_pkg.sv
// Shared PIMC message types: line/core identifiers, receiver FSM states
// and the notify strobe polarity.
package osmx_irq_pkg;

  localparam int unsigned IRQ_LINE_W = 8;
  localparam int unsigned CPU_ID_W   = 8;

  typedef logic [IRQ_LINE_W-1:0] irq_line_t;
  typedef logic [CPU_ID_W-1:0]   cpu_id_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RELEASE = 1'b1
  } rx_state_t;

  // notify is active-low on the PIMC message bus
  localparam logic NOTIFY_ASSERTED = 1'b0;

endpackage : osmx_irq_pkg

// File: rtl/irq_fifo.sv
// Synchronous FIFO with exact occupancy count; pushes when full and pops
// when empty are dropped, so the count never over- or underflows.
module irq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the pre-edge occupancy
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;

endmodule : irq_fifo

// File: rtl/pimc_irq_rx.sv
// Per-core PIMC message receiver: captures addressed line numbers into a
// pending queue, returns a one-cycle irqack and watches for a stuck notify.
module pimc_irq_rx
  import osmx_irq_pkg::*;
#(
  parameter cpu_id_t     CPU_ID      = 8'h00,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            notify,
  input  logic [IRQ_LINE_W-1:0]           lineno,
  input  logic [CPU_ID_W-1:0]             processor_id,
  output logic                            irqack,
  input  logic                            irq_enable,
  output logic                            irq_valid,
  output logic [IRQ_LINE_W-1:0]           irq_line,
  input  logic                            irq_claim,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] irq_count,
  output logic                            ack_err
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             irqack_nxt;
  logic             ack_err_nxt;
  logic             push_c;
  logic             accept_c;
  logic             fifo_full;
  logic             fifo_empty;

  assign accept_c = (notify == NOTIFY_ASSERTED) && (processor_id == CPU_ID) &&
                    irq_enable && !fifo_full;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      irqack  <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      irqack  <= irqack_nxt;
      ack_err <= ack_err_nxt;
    end
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_c) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (notify != NOTIFY_ASSERTED || cnt == CNT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: RELEASE never accepts, so a held message is not captured twice
  always_comb begin
    push_c      = 1'b0;
    irqack_nxt  = 1'b0;
    cnt_nxt     = cnt;
    ack_err_nxt = ack_err;
    case (state)
      IDLE: begin
        if (accept_c) begin
          push_c     = 1'b1;
          irqack_nxt = 1'b1;
          cnt_nxt    = '0;
        end
      end
      RELEASE: begin
        if (notify == NOTIFY_ASSERTED) begin
          if (cnt == CNT_LAST) ack_err_nxt = 1'b1;
          else                 cnt_nxt     = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  irq_fifo #(
    .WIDTH (IRQ_LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (irq_claim),
    .wdata (lineno),
    .rdata (irq_line),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (irq_count)
  );

  assign irq_valid = !fifo_empty;

endmodule : pimc_irq_rx
